img_pix_pack: RTL and testbench

- Upstream stage of the HDMI-in/UDP-out image packetiser, in the `cam_pclk` domain.
- Takes the raw HDMI receiver video stream (RGB888, VS, DE) and selects an output window from it: crop offset, then optional 1:1 or 2:1 decimation.
- Converts each kept pixel to RGB565 and packs two pixels per 32-bit word.
- Drives `img_vsync` / `img_data_en` / `img_data` to the packetiser. Words per output line = `OUT_H_PIXEL`/2; the packetiser's horizontal size must be set to that word count.

---
 rtl/img_pkt_pkg.sv | 32 +++
 rtl/img_win_cnt.sv | 67 ++++++
 rtl/img_pix_pack.sv | 101 ++++++++++
 tb/tb_img_pix_pack.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkt_pkg.sv
// Shared types and constants for the HDMI-in image packetiser.
// The packetiser imports the same window defaults, so both sides agree on words per line.
package img_pkt_pkg;

  localparam int RGB_W    = 24;
  localparam int RGB565_W = 16;
  localparam int WORD_W   = 32;

  localparam int R_HI = 23;
  localparam int R_LO = 19;
  localparam int G_HI = 15;
  localparam int G_LO = 10;
  localparam int B_HI = 7;
  localparam int B_LO = 3;

  localparam logic [15:0] DEF_OUT_H_PIXEL = 16'd640;
  localparam logic [15:0] DEF_OUT_V_PIXEL = 16'd480;
  localparam logic [15:0] DEF_X_OFF       = 16'd0;
  localparam logic [15:0] DEF_Y_OFF       = 16'd0;
  localparam logic [1:0]  DEF_DEC         = 2'd1;
  localparam logic        DEF_VS_POL      = 1'b1;

  typedef struct packed {
    logic             de;
    logic [RGB_W-1:0] rgb;
  } pix_in_t;

  function automatic logic [RGB565_W-1:0] to_rgb565(input logic [RGB_W-1:0] c);
    return {c[R_HI:R_LO], c[G_HI:G_LO], c[B_HI:B_LO]};
  endfunction

endpackage

// File: rtl/img_win_cnt.sv
// Window tracker: x/y counters, DE/VS edge detect and the per-frame enable latch.
// Produces the per-pixel keep flag and line/frame strobes, all aligned with stage 1.
module img_win_cnt
  import img_pkt_pkg::*;
#(
  parameter logic [15:0] OUT_H_PIXEL = DEF_OUT_H_PIXEL,
  parameter logic [15:0] OUT_V_PIXEL = DEF_OUT_V_PIXEL,
  parameter logic [15:0] X_OFF       = DEF_X_OFF,
  parameter logic [15:0] Y_OFF       = DEF_Y_OFF,
  parameter logic [1:0]  DEC         = DEF_DEC
) (
  input  logic cam_pclk,
  input  logic rst_n,
  input  logic vs,
  input  logic de,
  input  logic frame_en,
  output logic keep,
  output logic row_ok,
  output logic line_end,
  output logic frame_start
);

  // 17-bit bounds so X_OFF + span cannot wrap
  localparam logic [16:0] X_LO = 17'(X_OFF);
  localparam logic [16:0] X_HI = X_LO + 17'(OUT_H_PIXEL) * 17'(DEC);
  localparam logic [16:0] Y_LO = 17'(Y_OFF);
  localparam logic [16:0] Y_HI = Y_LO + 17'(OUT_V_PIXEL) * 17'(DEC);

  logic        vs_d, de_d, en_q;
  logic [15:0] x, y;
  logic        x_ok, y_ok;

  assign frame_start = vs & ~vs_d;
  assign line_end    = de_d & ~de;

  // with DEC limited to 1 or 2, the phase test reduces to comparing LSBs
  assign x_ok = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                ((DEC != 2'd2) || !(x[0] ^ X_OFF[0]));
  assign y_ok = ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI) &&
                ((DEC != 2'd2) || !(y[0] ^ Y_OFF[0]));

  assign row_ok = en_q & y_ok;
  assign keep   = de & row_ok & x_ok;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      en_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      vs_d <= vs;
      de_d <= de;
      if (frame_start) begin
        x    <= '0;
        y    <= '0;
        en_q <= frame_en;
      end else begin
        if (!de)           x <= '0;
        else if (x != '1)  x <= x + 16'd1;
        if (line_end && y != '1) y <= y + 16'd1;
      end
    end
  end

endmodule

// File: rtl/img_pix_pack.sv
// Crops/decimates the HDMI RGB888 stream, converts to RGB565 and packs two pixels per word.
// Stage 1 registers the inputs; stage 2 is the packed output, so data lags vin_de by 2 cycles.
module img_pix_pack
  import img_pkt_pkg::*;
#(
  parameter logic [15:0] OUT_H_PIXEL = DEF_OUT_H_PIXEL,
  parameter logic [15:0] OUT_V_PIXEL = DEF_OUT_V_PIXEL,
  parameter logic [15:0] X_OFF       = DEF_X_OFF,
  parameter logic [15:0] Y_OFF       = DEF_Y_OFF,
  parameter logic [1:0]  DEC         = DEF_DEC,
  parameter logic        VS_POL      = DEF_VS_POL
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              vin_vs,
  input  logic              vin_de,
  input  logic [RGB_W-1:0]  vin_data,
  input  logic              frame_en,
  output logic              img_vsync,
  output logic              img_data_en,
  output logic [WORD_W-1:0] img_data,
  output logic              short_line
);

  localparam int          STAGES = 2;
  localparam logic [15:0] WORDS  = OUT_H_PIXEL >> 1;

  logic                vs_n;
  logic [STAGES:1]     vs_pipe;
  pix_in_t             s1;
  logic                keep, row_ok, line_end, frame_start;
  logic [RGB565_W-1:0] pix565, hold;
  logic                pair_vld;
  logic [15:0]         word_cnt;

  assign vs_n      = vin_vs ~^ VS_POL;
  assign img_vsync = vs_pipe[STAGES];
  assign pix565    = to_rgb565(s1.rgb);

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_pipe <= '0;
      s1      <= '0;
    end else begin
      vs_pipe <= {vs_pipe[STAGES-1:1], vs_n};
      s1      <= '{de: vin_de, rgb: vin_data};
    end
  end

  img_win_cnt #(
    .OUT_H_PIXEL (OUT_H_PIXEL),
    .OUT_V_PIXEL (OUT_V_PIXEL),
    .X_OFF       (X_OFF),
    .Y_OFF       (Y_OFF),
    .DEC         (DEC)
  ) u_win (
    .cam_pclk    (cam_pclk),
    .rst_n       (rst_n),
    .vs          (vs_pipe[1]),
    .de          (s1.de),
    .frame_en    (frame_en),
    .keep        (keep),
    .row_ok      (row_ok),
    .line_end    (line_end),
    .frame_start (frame_start)
  );

  // frame start wins over everything so a mid-line restart never emits a partial word
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      pair_vld    <= 1'b0;
      word_cnt    <= '0;
      img_data    <= '0;
      img_data_en <= 1'b0;
      short_line  <= 1'b0;
    end else begin
      img_data_en <= 1'b0;
      short_line  <= 1'b0;
      if (frame_start) begin
        pair_vld <= 1'b0;
        word_cnt <= '0;
      end else if (keep) begin
        if (!pair_vld) begin
          hold     <= pix565;
          pair_vld <= 1'b1;
        end else begin
          img_data    <= {hold, pix565};
          img_data_en <= 1'b1;
          pair_vld    <= 1'b0;
          word_cnt    <= word_cnt + 16'd1;
        end
      end else if (line_end) begin
        pair_vld   <= 1'b0;
        word_cnt   <= '0;
        short_line <= row_ok && (word_cnt < WORDS);
      end
    end
  end

endmodule

// File: tb/tb_img_pix_pack.sv
// Scoreboard bench for img_pix_pack: 16x7 input frames, 4x2 window at (4,2), DEC=2, active-low VS.
module tb_img_pix_pack;

  localparam logic [15:0] P_OUT_H  = 16'd4;
  localparam logic [15:0] P_OUT_V  = 16'd2;
  localparam logic [15:0] P_X_OFF  = 16'd4;
  localparam logic [15:0] P_Y_OFF  = 16'd2;
  localparam logic [1:0]  P_DEC    = 2'd2;
  localparam logic        P_VS_POL = 1'b0;
  localparam int          NLINES   = 7;

  logic        cam_pclk = 1'b0;
  logic        rst_n    = 1'b1;
  logic        vin_vs   = ~P_VS_POL;
  logic        vin_de   = 1'b0;
  logic [23:0] vin_data = '0;
  logic        frame_en = 1'b0;
  logic        img_vsync, img_data_en, short_line;
  logic [31:0] img_data;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_word_t;

  exp_word_t wq[$];
  int        sq[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc    = 0;
  logic      exp_s1 = 1'b0;
  logic      exp_s2 = 1'b0;
  logic      done   = 1'b0;
  logic      fin    = 1'b0;

  img_pix_pack #(
    .OUT_H_PIXEL (P_OUT_H),
    .OUT_V_PIXEL (P_OUT_V),
    .X_OFF       (P_X_OFF),
    .Y_OFF       (P_Y_OFF),
    .DEC         (P_DEC),
    .VS_POL      (P_VS_POL)
  ) dut (
    .cam_pclk    (cam_pclk),
    .rst_n       (rst_n),
    .vin_vs      (vin_vs),
    .vin_de      (vin_de),
    .vin_data    (vin_data),
    .frame_en    (frame_en),
    .img_vsync   (img_vsync),
    .img_data_en (img_data_en),
    .img_data    (img_data),
    .short_line  (short_line)
  );

  always #5 cam_pclk = ~cam_pclk;

  always @(posedge cam_pclk) cyc <= cyc + 1;

  // expected img_vsync: active-high VS delayed two cycles
  always @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      exp_s1 <= 1'b0;
      exp_s2 <= 1'b0;
    end else begin
      exp_s1 <= (vin_vs == P_VS_POL);
      exp_s2 <= exp_s1;
    end
  end

  // monitor: runs 1 time unit after every falling clock edge and after reset assertion
  always @(negedge cam_pclk or negedge rst_n) begin
    exp_word_t e;
    int        s;
    #1;
    checks++;
    if (img_vsync !== exp_s2) begin
      errors++;
      $display("FAIL vsync cyc %0d got %b want %b", cyc, img_vsync, exp_s2);
    end
    if (!rst_n) begin
      checks += 3;
      if (img_data !== 32'h0) begin
        errors++;
        $display("FAIL rst_data cyc %0d got %h want 00000000", cyc, img_data);
      end
      if (img_data_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_data_en cyc %0d got %b want 0", cyc, img_data_en);
      end
      if (short_line !== 1'b0) begin
        errors++;
        $display("FAIL rst_short cyc %0d got %b want 0", cyc, short_line);
      end
    end
    if (img_data_en === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_unexpected cyc %0d got %h want no strobe", cyc, img_data);
      end else begin
        e = wq.pop_front();
        checks += 2;
        if (img_data !== e.data) begin
          errors++;
          $display("FAIL word_data cyc %0d got %h want %h", cyc, img_data, e.data);
        end
        if (cyc != e.at) begin
          errors++;
          $display("FAIL word_cycle got %0d want %0d", cyc, e.at);
        end
      end
    end
    if (short_line === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL short_unexpected cyc %0d got 1 want 0", cyc);
      end else begin
        s = sq.pop_front();
        if (cyc != s) begin
          errors++;
          $display("FAIL short_cycle got %0d want %0d", cyc, s);
        end
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      checks += 2;
      if (wq.size() != 0) begin
        errors++;
        $display("FAIL words_missing got %0d left want 0", wq.size());
      end
      if (sq.size() != 0) begin
        errors++;
        $display("FAIL short_missing got %0d left want 0", sq.size());
      end
    end
  end

  task automatic drive(input logic vs_act, input logic de, input logic [23:0] d);
    @(negedge cam_pclk);
    vin_vs   = vs_act ? P_VS_POL : ~P_VS_POL;
    vin_de   = de;
    vin_data = d;
  endtask

  task automatic push_w(input logic [31:0] d);
    exp_word_t e;
    e.data = d;
    e.at   = cyc + 2;
    wq.push_back(e);
  endtask

  // window lines 2 and 4 carry distinct colours at kept columns 4,6,8,10; everything else filler
  function automatic logic [23:0] pix(input int y, input int x);
    if (y == 2)
      case (x)
        4: return 24'hF80000;
        6: return 24'h00FC00;
        8: return 24'h0000F8;
        10: return 24'h123456;
        default: ;
      endcase
    if (y == 4)
      case (x)
        4: return 24'hFFFFFF;
        6: return 24'h000000;
        8: return 24'h080400;
        10: return 24'h070300;
        default: ;
      endcase
    return 24'hA5A5A5;
  endfunction

  function automatic int line_len(input int mode, input int y);
    if (mode != 1) return 16;
    if (y == 2) return 9;
    if (y == 4) return 11;
    return 5;
  endfunction

  // mode 0: full 16-pixel lines; mode 1: short lines; mode 2: reset after third kept pixel
  task automatic run_frame(input int mode, input logic en0, input int tog_line,
                           input logic en1, input logic exp_on);
    logic on;
    on = exp_on;
    frame_en = en0;
    repeat (2) drive(1'b0, 1'b0, 24'h0);
    repeat (2) drive(1'b1, 1'b0, 24'h0);
    repeat (3) drive(1'b0, 1'b0, 24'h0);
    for (int y = 0; y < NLINES; y++) begin
      int len;
      len = line_len(mode, y);
      if (y == tog_line) frame_en = en1;
      for (int x = 0; x < len; x++) begin
        drive(1'b0, 1'b1, pix(y, x));
        if (on) begin
          if (y == 2 && x == 6)  push_w(32'hF800_07E0);
          if (y == 2 && x == 10) push_w(32'h001F_11AA);
          if (y == 4 && x == 6)  push_w(32'hFFFF_0000);
          if (y == 4 && x == 10) push_w(32'h0820_0000);
        end
        if (mode == 2 && y == 2 && x == 8) begin
          #2 rst_n = 1'b0;
          @(negedge cam_pclk);
          rst_n = 1'b1;
          on = 1'b0;
        end
      end
      drive(1'b0, 1'b0, 24'h0);
      if (on && mode == 1 && y == 2) sq.push_back(cyc + 2);
      repeat (3) drive(1'b0, 1'b0, 24'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge cam_pclk);
    rst_n = 1'b1;
    run_frame(0, 1'b1, -1, 1'b1, 1'b1);  // basic window, conversion, latency
    run_frame(1, 1'b1, -1, 1'b1, 1'b1);  // short line 2, exact-length line 4
    run_frame(0, 1'b1,  1, 1'b0, 1'b1);  // enable dropped mid-frame: frame completes
    run_frame(0, 1'b0,  3, 1'b1, 1'b0);  // disabled frame, re-enabled mid-frame
    run_frame(0, 1'b1, -1, 1'b1, 1'b1);  // output resumes
    run_frame(2, 1'b1, -1, 1'b1, 1'b1);  // reset mid-line
    run_frame(0, 1'b1, -1, 1'b1, 1'b1);  // first frame after reset
    repeat (6) drive(1'b0, 1'b0, 24'h0);
    done = 1'b1;
    repeat (3) @(negedge cam_pclk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
